// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: default debounce timing and the
// helper that sizes the sample-tick counter.
package btn_pkg;

  localparam int unsigned DefTickDiv = 100000;
  localparam int unsigned DefDbLen   = 4;

  // Smallest counter width that can hold 0 .. div-1 (at least one bit).
  function automatic int unsigned tick_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-sampled shift register debouncer,
// registered clean level, press pulse and press-toggled level.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_LEN      = DefDbLen,
  parameter bit          TOGGLE_INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic toggle_o
);

  logic [1:0]        sync_q;
  logic [DB_LEN-1:0] shreg_q, shreg_d;
  logic              level_q, level_d;
  logic              pulse_q, toggle_q;
  logic              rise;

  always_comb begin
    shreg_d = shreg_q;
    if (tick_i) begin
      shreg_d = {shreg_q[DB_LEN-2:0], sync_q[1]};
    end

    // Mixed history keeps the current level; only a full run of equal samples moves it.
    level_d = level_q;
    if (&shreg_q) begin
      level_d = 1'b1;
    end else if (~|shreg_q) begin
      level_d = 1'b0;
    end

    rise = level_d & ~level_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      shreg_q  <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      toggle_q <= TOGGLE_INIT;
    end else begin
      sync_q   <= {sync_q[0], btn_raw_i};
      shreg_q  <= shreg_d;
      level_q  <= level_d;
      pulse_q  <= rise;
      toggle_q <= toggle_q ^ rise;
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign toggle_o = toggle_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: one shared debounce sample-tick generator feeding NUM_BTN
// independent synchronise/debounce/edge-detect channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned          NUM_BTN     = 3,
  parameter int unsigned          TICK_DIV    = DefTickDiv,
  parameter int unsigned          TICK_W      = tick_width(TICK_DIV),
  parameter int unsigned          DB_LEN      = DefDbLen,
  parameter logic [NUM_BTN-1:0]   TOGGLE_INIT = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic               tick_o,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_pulse_o,
  output logic [NUM_BTN-1:0] btn_toggle_o
);

  if ((64'd1 << TICK_W) < 64'(TICK_DIV)) begin : g_bad_tick_w
    $error("TICK_W too narrow for TICK_DIV");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 1");
  end
  if (DB_LEN < 2) begin : g_bad_db_len
    $error("DB_LEN must be at least 2");
  end

  localparam logic [TICK_W-1:0] CntLast = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == CntLast);
    cnt_d  = tick_d ? '0 : cnt_q + TICK_W'(1);
  end

  // Tick is registered, so it is high in the cycle right after the counter wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DB_LEN      (DB_LEN),
      .TOGGLE_INIT (TOGGLE_INIT[i])
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick_q),
      .btn_raw_i (btn_raw_i[i]),
      .level_o   (btn_level_o[i]),
      .pulse_o   (btn_pulse_o[i]),
      .toggle_o  (btn_toggle_o[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: expected press pulses are queued with a
// landing window when stimulus is applied and matched as the DUT emits them.
module tb_btn_conditioner;

  localparam int unsigned NB = 3;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic          tick;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_toggle;

  btn_conditioner #(
    .NUM_BTN     (NB),
    .TICK_DIV    (4),
    .DB_LEN      (4),
    .TOGGLE_INIT (3'b010)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .btn_raw_i    (btn_raw),
    .tick_o       (tick),
    .btn_level_o  (btn_level),
    .btn_pulse_o  (btn_pulse),
    .btn_toggle_o (btn_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NB-1:0] mask;
    logic [NB-1:0] toggle;
    int            earliest;
    int            latest;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic expect_pulse(input logic [NB-1:0] mask, input logic [NB-1:0] tog,
                              input int earliest, input int latest);
    exp_t e;
    e.mask     = mask;
    e.toggle   = tog;
    e.earliest = earliest;
    e.latest   = latest;
    sb_q.push_back(e);
  endtask

  // Pulse monitor: any pulse must match the oldest queued expectation in its window.
  always @(negedge clk) begin
    if (btn_pulse != '0) begin
      if (sb_q.size() == 0) begin
        check("spurious_pulse", 32'(btn_pulse), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_mask", 32'(btn_pulse), 32'(mon_e.mask));
        check("pulse_toggle", 32'(btn_toggle), 32'(mon_e.toggle));
        check("pulse_level", 32'(btn_level & mon_e.mask), 32'(mon_e.mask));
        check("pulse_not_early", 32'(cyc >= mon_e.earliest), 32'h1);
        check("pulse_not_late", 32'(cyc <= mon_e.latest), 32'h1);
      end
    end
    if (sb_q.size() != 0 && cyc > sb_q[0].latest) begin
      check("pulse_missing", 32'(btn_pulse), 32'(sb_q[0].mask));
      void'(sb_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int r;   // cycle count at the last reset release; fixes the tick phase
  int c;
  int e1;

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;

    // 1. Reset values and tick cadence
    wait_cyc(3);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_level", 32'(btn_level), 32'h0);
    check("rst_pulse", 32'(btn_pulse), 32'h0);
    check("rst_toggle", 32'(btn_toggle), 32'h2);
    rst_n = 1'b1;
    r = cyc;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("tick_k%0d", k), 32'(tick), 32'((k % 4) == 0));
    end
    check("idle_level", 32'(btn_level), 32'h0);
    check("idle_toggle", 32'(btn_toggle), 32'h2);

    // 2. Clean press on channel 0, then release
    @(negedge clk);
    btn_raw[0] = 1'b1;
    c = cyc;
    expect_pulse(3'b001, 3'b011, c + 16, c + 19);
    wait_cyc(30);
    check("t2_level_held", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b0;
    wait_cyc(25);
    check("t2_level_released", 32'(btn_level), 32'h0);
    check("t2_toggle", 32'(btn_toggle), 32'h3);

    // 3. Glitch on channel 1 lasting three ticks
    btn_raw[1] = 1'b1;
    wait_cyc(12);
    btn_raw[1] = 1'b0;
    wait_cyc(25);
    check("t3_level", 32'(btn_level), 32'h0);
    check("t3_toggle", 32'(btn_toggle), 32'h3);

    // 4. Bounce on channel 2; sampled phase of the bounce is always low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_raw[2] = ((cyc - r) % 2) == 1;
    end
    @(negedge clk);
    btn_raw[2] = 1'b1;
    c = cyc;
    expect_pulse(3'b100, 3'b111, c + 16, c + 19);
    wait_cyc(30);
    check("t4_level_held", 32'(btn_level), 32'h4);
    btn_raw[2] = 1'b0;
    wait_cyc(25);
    check("t4_level_released", 32'(btn_level), 32'h0);
    check("t4_toggle", 32'(btn_toggle), 32'h7);

    // 5. Simultaneous press on channels 0 and 2
    btn_raw = 3'b101;
    c = cyc;
    expect_pulse(3'b101, 3'b010, c + 16, c + 19);
    wait_cyc(30);
    check("t5_level", 32'(btn_level), 32'h5);
    btn_raw = 3'b000;
    wait_cyc(25);
    check("t5_toggle", 32'(btn_toggle), 32'h2);

    // 6. Reset while channel 0 is mid-qualification and channel 1 is pressed
    btn_raw[1] = 1'b1;
    c = cyc;
    expect_pulse(3'b010, 3'b000, c + 16, c + 19);
    wait_cyc(22);
    check("t6_pre_level", 32'(btn_level), 32'h2);
    btn_raw[0] = 1'b1;
    c = cyc;
    e1 = c + 3;
    while (((e1 - r) % 4) != 1) e1++;
    while (cyc < e1 + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_level", 32'(btn_level), 32'h0);
    check("t6_async_toggle", 32'(btn_toggle), 32'h2);
    check("t6_async_pulse", 32'(btn_pulse), 32'h0);
    check("t6_async_tick", 32'(tick), 32'h0);
    wait_cyc(3);
    check("t6_hold_level", 32'(btn_level), 32'h0);
    check("t6_hold_toggle", 32'(btn_toggle), 32'h2);
    rst_n = 1'b1;
    r = cyc;
    expect_pulse(3'b011, 3'b001, r + 18, r + 18);
    wait_cyc(22);
    check("t6_level_after", 32'(btn_level), 32'h3);
    check("t6_toggle_after", 32'(btn_toggle), 32'h1);
    btn_raw = '0;
    wait_cyc(25);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
